jtopl_eg_ctrl_seq: RTL

//  Envelope sequencer directly upstream of the EG arithmetic stage (jtopl_eg_pure).

---
 rtl/jtopl_eg_ctrl_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/jtopl_eg_ctrl_seq.sv
// rtl/jtopl_eg_ctrl_seq.sv - per-slot ADSR sequencer feeding the EG arithmetic stage (optional JTOPL_EG_DEBUG_EN adds dbg_state_o)
module jtopl_eg_ctrl_seq #(
  parameter int SLOTS = 18,
  parameter int CNTW  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen_i,
  input  logic       keyon_i,
  input  logic       en_sus_i,
  input  logic       ksr_i,
  input  logic [3:0] keycode_i,
  input  logic [3:0] arate_i,
  input  logic [3:0] drate_i,
  input  logic [3:0] rrate_i,
  input  logic [3:0] sl_i,
  input  logic [9:0] eg_pure_i,
  output logic [4:0] slot_o,
  output logic       attack_o,
  output logic       step_o,
  output logic [4:0] rate_o,
  output logic       sum_up_o,
  output logic [9:0] eg_in_o,
  output logic [9:0] eg_out_o
`ifdef JTOPL_EG_DEBUG_EN
  ,
  output logic [1:0] dbg_state_o
`endif
);

  typedef enum logic [1:0] {
    ST_ATTACK  = 2'd0,
    ST_DECAY   = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } eg_state_e;

  localparam logic [4:0]      LAST_SLOT = 5'(SLOTS - 1);
  localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};

  eg_state_e        state_q [SLOTS];
  logic [9:0]       eg_q    [SLOTS];
  logic [SLOTS-1:0] kon_q;
  logic [4:0]       slot_q, slot_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [9:0]       eg_out_q;
  eg_state_e        cur_st, st_d;
`ifdef JTOPL_EG_DEBUG_EN
  eg_state_e        dbg_q;
`endif

  logic [3:0]       base;
  logic [3:0]       kc_add;
  logic [6:0]       eff_sum;
  logic [5:0]       eff;
  logic [3:0]       shift;
  logic [CNTW-1:0]  mask;
  logic [CNTW-1:0]  cnt_shifted;
  logic [2:0]       step_idx;
  logic [7:0]       pattern;
  logic [4:0]       sl_lim;

  assign cur_st = state_q[slot_q];

  // Effective rate: base rate from the slot state plus key scaling, saturated to 6 bits
  always_comb begin
    base = 4'd0;
    unique case (cur_st)
      ST_ATTACK:  base = arate_i;
      ST_DECAY:   base = drate_i;
      ST_SUSTAIN: base = en_sus_i ? 4'd0 : rrate_i;
      ST_RELEASE: base = rrate_i;
      default:    base = rrate_i;
    endcase
    kc_add  = ksr_i ? keycode_i : {2'b00, keycode_i[3:2]};
    eff_sum = {1'b0, base, 2'b00} + {3'b000, kc_add};
    if (base == 4'd0) begin
      eff = 6'd0;
    end else if (eff_sum[6]) begin
      eff = 6'd63;
    end else begin
      eff = eff_sum[5:0];
    end
  end

  // Counter gating: slow rates update only when the low eg_cnt bits are zero
  always_comb begin
    shift = (eff[5:2] >= 4'd12) ? 4'd0 : (4'd11 - eff[5:2]);
    mask        = (CNT_ONE << shift) - CNT_ONE;
    cnt_shifted = cnt_q >> shift;
    step_idx    = cnt_shifted[2:0];
    pattern     = 8'b10101010;
    unique case (eff[1:0])
      2'd0: pattern = 8'b10101010;
      2'd1: pattern = 8'b11101010;
      2'd2: pattern = 8'b11101110;
      2'd3: pattern = 8'b11111110;
      default: pattern = 8'b10101010;
    endcase
    sum_up_o = (eff != 6'd0) && ((cnt_q & mask) == '0);
    step_o   = (eff != 6'd0) && pattern[step_idx];
  end

  // Next ADSR state of the current slot, key-on edge has top priority
  always_comb begin
    sl_lim = (sl_i == 4'hF) ? 5'd31 : {1'b0, sl_i};
    st_d   = cur_st;
    if (keyon_i && !kon_q[slot_q]) begin
      st_d = ST_ATTACK;
    end else if (!keyon_i && cur_st != ST_RELEASE) begin
      st_d = ST_RELEASE;
    end else if (cur_st == ST_ATTACK && eg_pure_i == 10'd0) begin
      st_d = ST_DECAY;
    end else if (cur_st == ST_DECAY && eg_pure_i[9:5] >= sl_lim) begin
      st_d = ST_SUSTAIN;
    end
  end

  // Slot sequencing and global envelope counter advance on slot wrap
  always_comb begin
    slot_d = (slot_q == LAST_SLOT) ? 5'd0 : slot_q + 5'd1;
    cnt_d  = (slot_q == LAST_SLOT) ? cnt_q + CNT_ONE : cnt_q;
  end

  // State, attenuation and key-on history storage, written for the current slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= 5'd0;
      cnt_q    <= '0;
      kon_q    <= '0;
      eg_out_q <= 10'h3FF;
      for (int i = 0; i < SLOTS; i++) begin
        state_q[i] <= ST_RELEASE;
        eg_q[i]    <= 10'h3FF;
      end
`ifdef JTOPL_EG_DEBUG_EN
      dbg_q    <= ST_RELEASE;
`endif
    end else if (cen_i) begin
      slot_q          <= slot_d;
      cnt_q           <= cnt_d;
      kon_q[slot_q]   <= keyon_i;
      eg_out_q        <= eg_pure_i;
      state_q[slot_q] <= st_d;
      eg_q[slot_q]    <= eg_pure_i;
`ifdef JTOPL_EG_DEBUG_EN
      dbg_q           <= st_d;
`endif
    end
  end

  assign slot_o   = slot_q;
  assign attack_o = (cur_st == ST_ATTACK);
  assign rate_o   = eff[5:1];
  assign eg_in_o  = eg_q[slot_q];
  assign eg_out_o = eg_out_q;
`ifdef JTOPL_EG_DEBUG_EN
  assign dbg_state_o = dbg_q;
`endif

endmodule
